cpu_step_ctrl: RTL and testbench

Run/step controller for the single-cycle RISC-V CPU, sitting in the 100 MHz `fast_clk` domain. It consumes the divided `slow_clk` from the clock divider, along with a board step button and mode switches. From these it produces a single-cycle `cpu_en` clock-enable strobe, so the CPU core runs on `fast_clk` and never uses the divided clock as a clock. It provides free-run, single-step and halt modes, plus an instruction-issue counter for display.

---
 rtl/cpu_ctrl_pkg.sv | 15 +
 rtl/sync_edge.sv | 45 ++++
 rtl/cpu_step_ctrl.sv | 125 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/step controller: FSM states and mode-switch values.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    localparam logic [1:0] MODE_HALT     = 2'b00;
    localparam logic [1:0] MODE_RUN      = 2'b01;
    localparam logic [1:0] MODE_STEP     = 2'b10;
    localparam logic [1:0] MODE_HALT_ALT = 2'b11;

endpackage

// File: rtl/sync_edge.sv
// Optional N-flop synchronizer followed by a registered rising-edge pulse.
// STAGES=0 gives a plain edge detector for signals already in the clock domain.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic synced;
    logic prev_q;
    logic rise_q;

    if (STAGES > 0) begin : g_sync
        logic [STAGES-1:0] chain_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                chain_q <= '0;
            end else begin
                chain_q <= STAGES'({chain_q, d_i});
            end
        end

        assign synced = chain_q[STAGES-1];
    end else begin : g_nosync
        assign synced = d_i;
    end

    // The pulse is registered so the tick comes from a flop, not from logic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= synced;
            rise_q <= synced & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: turns the divided clock level and a debounced step button into a
// one-cycle CPU advance strobe on fast_clk, with a sticky halt and an issue counter.
//   state   | meaning
//   ST_HALT | no strobes; also forced while halted or mode is 00/11
//   ST_RUN  | one strobe per slow_clk rising edge
//   ST_STEP | one strobe per debounced button press
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        fast_clk,
    input  logic        rst,
    input  logic        slow_clk,
    input  logic        step_btn,
    input  logic [1:0]  mode_sw,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        halted,
    output logic [31:0] step_count
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0]      btn_sync_q;
    logic [SYNC_STAGES-1:0][1:0] mode_sync_q;
    logic                        btn_s;
    logic [1:0]                  mode_s;

    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_lvl_q, deb_lvl_d;

    state_e      state_q, state_d;
    logic        halted_q, halted_d;
    logic        cpu_en_q, cpu_en_d;
    logic [31:0] step_count_q, step_count_d;

    logic run_tick;
    logic step_tick;

    sync_edge #(.STAGES(SYNC_STAGES)) u_slow_edge (
        .clk_i  (fast_clk),
        .rst_i  (rst),
        .d_i    (slow_clk),
        .rise_o (run_tick)
    );

    // The debounced level is already in this domain, so only the edge register is needed.
    sync_edge #(.STAGES(0)) u_step_edge (
        .clk_i  (fast_clk),
        .rst_i  (rst),
        .d_i    (deb_lvl_q),
        .rise_o (step_tick)
    );

    assign btn_s  = btn_sync_q[SYNC_STAGES-1];
    assign mode_s = mode_sync_q[SYNC_STAGES-1];

    always_comb begin
        deb_cnt_d    = deb_cnt_q;
        deb_lvl_d    = deb_lvl_q;
        state_d      = ST_HALT;
        halted_d     = halted_q;
        cpu_en_d     = 1'b0;
        step_count_d = step_count_q;

        if (btn_s == deb_lvl_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == CNT_LAST) begin
            deb_lvl_d = ~deb_lvl_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end

        if (!halted_q) begin
            case (mode_s)
                MODE_RUN:  state_d = ST_RUN;
                MODE_STEP: state_d = ST_STEP;
                default:   state_d = ST_HALT;
            endcase
        end

        // Set beats clear so a fault while parked in HALT is not lost.
        if (mode_s == MODE_HALT) halted_d = 1'b0;
        if (halt_req)            halted_d = 1'b1;

        cpu_en_d = ((state_q == ST_RUN  && run_tick) ||
                    (state_q == ST_STEP && step_tick)) &&
                   !halt_req && !halted_q && !cpu_en_q;

        if (cpu_en_q) step_count_d = step_count_q + 32'd1;
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            btn_sync_q   <= '0;
            mode_sync_q  <= '0;
            deb_cnt_q    <= '0;
            deb_lvl_q    <= 1'b0;
            state_q      <= ST_HALT;
            halted_q     <= 1'b0;
            cpu_en_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], step_btn};
            mode_sync_q  <= {mode_sync_q[SYNC_STAGES-2:0], mode_sw};
            deb_cnt_q    <= deb_cnt_d;
            deb_lvl_q    <= deb_lvl_d;
            state_q      <= state_d;
            halted_q     <= halted_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign state      = state_q;
    assign halted     = halted_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_cpu_step_ctrl;

    logic        fast_clk = 1'b0;
    logic        rst      = 1'b1;
    logic        slow_clk = 1'b0;
    logic        step_btn = 1'b0;
    logic [1:0]  mode_sw  = 2'b00;
    logic        halt_req = 1'b0;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] step_count;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    logic [31:0] exp_cnt = '0;
    logic        prev_en = 1'b0;

    cpu_step_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .fast_clk   (fast_clk),
        .rst        (rst),
        .slow_clk   (slow_clk),
        .step_btn   (step_btn),
        .mode_sw    (mode_sw),
        .halt_req   (halt_req),
        .cpu_en     (cpu_en),
        .state      (state),
        .halted     (halted),
        .step_count (step_count)
    );

    always #5 fast_clk = ~fast_clk;

    always @(posedge fast_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pops one expectation for every strobe the DUT presents.
    always @(negedge fast_clk) begin
        exp_t e;
        if (!rst && cpu_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_count", step_count, e.cnt);
            end
            if (prev_en) begin
                n_cmp++;
                n_err++;
                $display("FAIL back_to_back: cpu_en=1 on consecutive cycles at %0d, required single", cyc);
            end
        end
        prev_en = cpu_en;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge fast_clk);
    endtask

    task automatic slow_edge(input bit expect_pulse);
        slow_clk = 1'b1;
        if (expect_pulse) begin
            exp_q.push_back('{cyc + 4, exp_cnt});
            exp_cnt++;
        end
        wait_cyc(10);
        slow_clk = 1'b0;
        wait_cyc(10);
    endtask

    task automatic drain(input string name);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        wait_cyc(3);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_state", state, 2'b00);
        check("rst_halted", halted, 0);
        check("rst_count", step_count, 0);

        rst     = 1'b0;
        mode_sw = 2'b01;
        wait_cyc(2);
        check("run_entry_early", state, 2'b00);
        wait_cyc(1);
        check("run_entry", state, 2'b01);

        repeat (5) slow_edge(1'b1);
        drain("run_drain");
        check("run_count", step_count, 5);

        // Async reset while a strobe is one edge away.
        slow_clk = 1'b1;
        wait_cyc(3);
        #2;
        rst      = 1'b1;
        slow_clk = 1'b0;
        #1;
        check("arst_cpu_en", cpu_en, 0);
        check("arst_state", state, 2'b00);
        check("arst_halted", halted, 0);
        check("arst_count", step_count, 0);
        exp_cnt = '0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        check("arst_run_entry", state, 2'b01);
        wait_cyc(6);
        check("arst_no_pulse", step_count, 0);

        mode_sw = 2'b10;
        wait_cyc(4);
        check("step_entry", state, 2'b10);
        step_btn = 1'b1; wait_cyc(1);
        step_btn = 1'b0; wait_cyc(1);
        step_btn = 1'b1; wait_cyc(1);
        step_btn = 1'b0; wait_cyc(12);
        check("glitch_count", step_count, exp_cnt);
        step_btn = 1'b1;
        exp_q.push_back('{cyc + 8, exp_cnt});
        exp_cnt++;
        wait_cyc(20);
        check("step_count", step_count, exp_cnt);
        step_btn = 1'b0;
        wait_cyc(15);
        drain("step_drain");
        check("release_count", step_count, exp_cnt);

        mode_sw = 2'b01;
        wait_cyc(4);
        check("halt_run_entry", state, 2'b01);
        slow_clk = 1'b1;
        wait_cyc(3);
        halt_req = 1'b1;
        wait_cyc(1);
        halt_req = 1'b0;
        check("halt_no_strobe", cpu_en, 0);
        check("halt_set", halted, 1);
        wait_cyc(1);
        check("halt_state", state, 2'b00);
        wait_cyc(8);
        slow_clk = 1'b0;
        wait_cyc(10);
        repeat (2) slow_edge(1'b0);
        check("halt_count", step_count, exp_cnt);
        check("halt_sticky", halted, 1);
        mode_sw = 2'b00;
        wait_cyc(5);
        check("halt_clear", halted, 0);
        mode_sw = 2'b01;
        wait_cyc(4);
        check("resume_state", state, 2'b01);
        slow_edge(1'b1);
        drain("resume_drain");

        mode_sw = 2'b11;
        wait_cyc(4);
        check("mode11_state", state, 2'b00);
        mode_sw = 2'b10;
        wait_cyc(4);
        check("cross_step_entry", state, 2'b10);
        repeat (2) slow_edge(1'b0);
        mode_sw = 2'b01;
        wait_cyc(4);
        check("cross_run_entry", state, 2'b01);
        step_btn = 1'b1;
        wait_cyc(12);
        step_btn = 1'b0;
        wait_cyc(12);
        drain("cross_drain");
        check("cross_count", step_count, exp_cnt);

        force dut.step_count_q = 32'hFFFF_FFFF;
        wait_cyc(1);
        release dut.step_count_q;
        exp_cnt = 32'hFFFF_FFFF;
        wait_cyc(1);
        check("wrap_preload", step_count, 32'hFFFF_FFFF);
        slow_edge(1'b1);
        check("wrap_count", step_count, 0);
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
